// File: rtl/dct_pkg.sv
// Shared constants for the 16-point inverse DCT odd-part accumulator.
// The odd matrix is split into a magnitude-select table and a sign table.
package dct_pkg;
   localparam int COEF_W = 18;
   localparam int OUT_W  = 27;
   localparam int N      = 8;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   // Bit n set means M[i][n] is negative.
   localparam logic [N-1:0] M_NEG [N] = '{
      8'b0000_0000,
      8'b1111_1000,
      8'b0001_1100,
      8'b1100_0110,
      8'b0011_0110,
      8'b1001_0010,
      8'b0100_1010,
      8'b1010_1010
   };

   // Index into the multiples {9,25,43,57,70,80,87,90} for |M[i][n]|.
   localparam logic [2:0] M_SEL [N][N] = '{
      '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
      '{3'd6, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7, 3'd4, 3'd1},
      '{3'd5, 3'd0, 3'd4, 3'd6, 3'd1, 3'd3, 3'd7, 3'd2},
      '{3'd4, 3'd2, 3'd6, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3},
      '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4},
      '{3'd2, 3'd7, 3'd3, 3'd1, 3'd6, 3'd4, 3'd0, 3'd5},
      '{3'd1, 3'd4, 3'd7, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6},
      '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}
   };
endpackage

// File: rtl/sau_8o_inv.sv
// Shift-and-add unit: the eight odd-matrix magnitude multiples of one coefficient.
module sau_8o_inv
   import dct_pkg::*;
(
   input  logic signed [COEF_W-1:0] x,
   output logic signed [OUT_W-1:0]  mul [N]
);
   logic signed [OUT_W-1:0] xe;

   assign xe = {{(OUT_W-COEF_W){x[COEF_W-1]}}, x};

   always_comb begin
      mul[0] = (xe <<< 3) + xe;                                  // 9
      mul[1] = (xe <<< 4) + (xe <<< 3) + xe;                     // 25
      mul[2] = (xe <<< 5) + (xe <<< 3) + (xe <<< 1) + xe;        // 43
      mul[3] = (xe <<< 6) - (xe <<< 3) + xe;                     // 57
      mul[4] = (xe <<< 6) + (xe <<< 2) + (xe <<< 1);             // 70
      mul[5] = (xe <<< 6) + (xe <<< 4);                          // 80
      mul[6] = (xe <<< 6) + (xe <<< 4) + (xe <<< 3) - xe;        // 87
      mul[7] = (xe <<< 6) + (xe <<< 4) + (xe <<< 3) + (xe <<< 1); // 90
   end
endmodule

// File: rtl/idct16_odd_acc.sv
// Accumulates eight odd-row coefficients into the eight odd outputs O[n];
// a result register keeps the finished block while the next one accumulates.
module idct16_odd_acc
   import dct_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [COEF_W-1:0] in_coef,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_o0,
   output logic signed [OUT_W-1:0]  out_o1,
   output logic signed [OUT_W-1:0]  out_o2,
   output logic signed [OUT_W-1:0]  out_o3,
   output logic signed [OUT_W-1:0]  out_o4,
   output logic signed [OUT_W-1:0]  out_o5,
   output logic signed [OUT_W-1:0]  out_o6,
   output logic signed [OUT_W-1:0]  out_o7
);
   state_t                  state, state_nxt;
   logic [2:0]              idx;
   logic                    accept;
   logic signed [OUT_W-1:0] mul     [N];
   logic signed [OUT_W-1:0] term    [N];
   logic signed [OUT_W-1:0] base    [N];
   logic signed [OUT_W-1:0] acc     [N];
   logic signed [OUT_W-1:0] acc_nxt [N];
   logic signed [OUT_W-1:0] res     [N];

   sau_8o_inv u_sau (.x(in_coef), .mul(mul));

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = ACC;
         ACC:  if (accept && idx == 3'd7) state_nxt = HOLD;
         HOLD: if (out_ready) state_nxt = accept ? ACC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state != HOLD) || out_ready;
      out_valid = (state == HOLD);
   end

   // Outside ACC the beat starts a fresh block, so the sums load rather than add.
   always_comb begin
      for (int n = 0; n < N; n++) begin
         term[n]    = mul[M_SEL[idx][n]];
         base[n]    = (state == ACC) ? acc[n] : '0;
         acc_nxt[n] = M_NEG[idx][n] ? base[n] - term[n] : base[n] + term[n];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         for (int n = 0; n < N; n++) begin
            acc[n] <= '0;
            res[n] <= '0;
         end
      end else if (accept) begin
         idx <= idx + 3'd1;
         for (int n = 0; n < N; n++) begin
            acc[n] <= acc_nxt[n];
            if (idx == 3'd7) res[n] <= acc_nxt[n];
         end
      end
   end

   assign out_o0 = res[0];
   assign out_o1 = res[1];
   assign out_o2 = res[2];
   assign out_o3 = res[3];
   assign out_o4 = res[4];
   assign out_o5 = res[5];
   assign out_o6 = res[6];
   assign out_o7 = res[7];
endmodule

// File: tb/tb_idct16_odd_acc.sv
// Scoreboard bench for idct16_odd_acc: expected blocks are queued at issue time
// and a negedge monitor pops and compares on every output transfer.
module tb_idct16_odd_acc;
   typedef logic [7:0][26:0] vec_t;

   localparam int M [8][8] = '{
      '{90, 87, 80, 70, 57, 43, 25,  9},
      '{87, 57,  9,-43,-80,-90,-70,-25},
      '{80,  9,-70,-87,-25, 57, 90, 43},
      '{70,-43,-87,  9, 90, 25,-80,-57},
      '{57,-80,-25, 90, -9,-87, 43, 70},
      '{43,-90, 57, 25,-87, 70,  9,-80},
      '{25,-70, 90,-80, 43,  9,-57, 87},
      '{ 9,-25, 43,-57, 70,-80, 87,-90}
   };

   logic               clk = 1'b0;
   logic               rst, in_valid, in_ready, out_valid, out_ready;
   logic signed [17:0] in_coef;
   vec_t               obs;
   bit                 rnd_rdy;
   int                 checks = 0;
   int                 errors = 0;
   vec_t               exp_q [$];

   idct16_odd_acc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_o0(obs[0]), .out_o1(obs[1]), .out_o2(obs[2]), .out_o3(obs[3]),
      .out_o4(obs[4]), .out_o5(obs[5]), .out_o6(obs[6]), .out_o7(obs[7])
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t gold(input int c[8]);
      vec_t   g;
      longint s;
      for (int n = 0; n < 8; n++) begin
         s = 0;
         for (int i = 0; i < 8; i++) s += longint'(c[i]) * M[i][n];
         g[n] = s[26:0];
      end
      return g;
   endfunction

   function automatic vec_t pk(input int v[8]);
      vec_t r;
      for (int n = 0; n < 8; n++) r[n] = v[n][26:0];
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic beat(input int c, input bit gaps);
      int waited = 0;
      if (gaps) while ($urandom_range(0, 2) == 0) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_coef  = 18'(c);
      @(negedge clk);
      while (!in_ready) begin
         waited++;
         if (waited > 200) begin
            $display("FAIL beat_timeout actual=stalled required=accepted");
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "in_ready never asserted");
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input int c[8], input bit gaps);
      for (int i = 0; i < 8; i++) beat(c[i], gaps);
   endtask

   initial forever begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: ordered compare on transfer, stability check while stalled.
   initial begin : monitor
      vec_t e, prev_o;
      bit   prev_v, prev_r;
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_o = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            continue;
         end
         if (prev_v && !prev_r) begin
            chk("valid_stable", longint'(out_valid), 1);
            for (int n = 0; n < 8; n++) chk($sformatf("hold_o%0d", n), longint'(obs[n]), longint'(prev_o[n]));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual=valid required=no_output t=%0t", $time);
            end else begin
               e = exp_q.pop_front();
               for (int n = 0; n < 8; n++)
                  chk($sformatf("o%0d", n), longint'($signed(obs[n])), longint'($signed(e[n])));
            end
         end
         prev_v = out_valid;
         prev_r = out_ready;
         prev_o = obs;
      end
   end

   initial begin
      int cv[8], cb[8], ev[8];
      logic signed [17:0] r;
      int waited;
      rst = 1'b1; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1; rnd_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      for (int n = 0; n < 8; n++) chk("rst_out", longint'($signed(obs[n])), 0);
      @(posedge clk); #1;

      // Unit impulse on row k=1, then latency check.
      cv = '{1, 0, 0, 0, 0, 0, 0, 0};
      ev = '{90, 87, 80, 70, 57, 43, 25, 9};
      exp_q.push_back(pk(ev));
      send(cv, 1'b0);
      @(negedge clk);
      chk("latency_valid", longint'(out_valid), 1);
      @(posedge clk); #1;

      cv = '{0, 0, 0, 0, 0, 0, 0, -1};
      ev = '{-9, 25, -43, 57, -70, 80, -87, 90};
      exp_q.push_back(pk(ev));
      send(cv, 1'b0);

      cv = '{-131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072};
      exp_q.push_back(gold(cv));
      send(cv, 1'b0);
      @(negedge clk);
      chk("min_o0", longint'($signed(obs[0])), -60424192);
      @(posedge clk); #1;

      // Backpressure for 5 cycles, then transfer overlapping the next c[0].
      cv = '{3, -7, 11, -13, 17, -19, 23, -29};
      cb = '{100, 200, -300, 400, -500, 600, -700, 800};
      out_ready = 1'b0;
      exp_q.push_back(gold(cv));
      send(cv, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_in_ready", longint'(in_ready), 0);
         chk("stall_out_valid", longint'(out_valid), 1);
         @(posedge clk); #1;
      end
      exp_q.push_back(gold(cb));
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_coef   = 18'(cb[0]);
      @(negedge clk);
      chk("overlap_in_ready", longint'(in_ready), 1);
      chk("overlap_out_valid", longint'(out_valid), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i < 8; i++) beat(cb[i], 1'b0);

      // Reset mid-block: partial sums dropped, next block starts clean.
      cv = '{5, -3, 7, 2, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) beat(cv[i], 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_out_valid", longint'(out_valid), 0);
         chk("midrst_in_ready", longint'(in_ready), 1);
      end
      chk("midrst_o0", longint'($signed(obs[0])), 0);
      @(posedge clk); #1;
      cv = '{1, 1, 1, 1, 1, 1, 1, 1};
      ev = '{461, -155, 97, -73, 59, -53, 47, -43};
      exp_q.push_back(pk(ev));
      send(cv, 1'b0);

      // Reset while a finished result is pending.
      cv = '{9, 8, 7, 6, 5, 4, 3, 2};
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(cv, 1'b0);
      @(negedge clk);
      chk("pending_valid", longint'(out_valid), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("holdrst_out_valid", longint'(out_valid), 0);
      end
      @(posedge clk); #1;

      // Random blocks with random gaps on both handshakes.
      rnd_rdy = 1'b1;
      for (int b = 0; b < 100; b++) begin
         for (int i = 0; i < 8; i++) begin
            r = 18'($urandom);
            cv[i] = int'(r);
         end
         exp_q.push_back(gold(cv));
         send(cv, 1'b1);
      end
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      waited = 0;
      while (exp_q.size() != 0 && waited < 100) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         waited++;
      end
      chk("drain_pending", longint'(exp_q.size()), 0);
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
